configurador_ventana: RTL

- Bus initiator for the window-configuration register interface.
- Accepts one configuration request (image start address, memory read count, internal buffer count) via valid/ready handshake.
- Validates it, then issues three single-cycle register writes on the address/data/enable bus at register addresses 0, 1, 2.
- Signals completion to the top-level controller so the filter pipeline can start.

---
 rtl/configurador_ventana.sv | 123 ++++++++++++
 1 files changed

// File: rtl/configurador_ventana.sv
// Bus initiator that takes one window-configuration request and writes the start
// address, read count and buffer count to register addresses 0, 1 and 2.
module configurador_ventana #(
  parameter int BITS_BUS_DATOS_INSTR     = 24,
  parameter int BITS_BUS_DIRECCION_INSTR = 8,
  parameter int BITS_DIRECCION_MEM       = 10,
  parameter int BITS_BUFFERS             = 3,
  parameter int CICLOS_ESPERA            = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                solicitud,
  output logic                                listo,
  input  logic [BITS_DIRECCION_MEM-1:0]       direccion_inicio,
  input  logic [BITS_DIRECCION_MEM-1:0]       cantidad_lecturas,
  input  logic [BITS_BUFFERS-1:0]             cantidad_buffers,
  output logic [BITS_BUS_DIRECCION_INSTR-1:0] direccion_registros,
  output logic [BITS_BUS_DATOS_INSTR-1:0]     datos_registros,
  output logic                                habilitacion_registros,
  output logic                                configuracion_completa,
  output logic                                error_configuracion
);

  typedef enum logic [2:0] {
    REPOSO, ESCRIBE_DIR, ESCRIBE_LECT, ESCRIBE_BUF, ESPERA, FIN, ERROR
  } estado_t;

  localparam bit         HAY_ESPERA   = (CICLOS_ESPERA > 0);
  localparam logic [3:0] CARGA_ESPERA = HAY_ESPERA ? 4'(CICLOS_ESPERA - 1) : 4'd0;

  localparam logic [BITS_BUS_DIRECCION_INSTR-1:0] REG_DIR  = BITS_BUS_DIRECCION_INSTR'(0);
  localparam logic [BITS_BUS_DIRECCION_INSTR-1:0] REG_LECT = BITS_BUS_DIRECCION_INSTR'(1);
  localparam logic [BITS_BUS_DIRECCION_INSTR-1:0] REG_BUF  = BITS_BUS_DIRECCION_INSTR'(2);

  estado_t                         estado_q, estado_sig;
  logic [BITS_DIRECCION_MEM-1:0]   lecturas_q;
  logic [BITS_BUFFERS-1:0]         buffers_q;
  logic [3:0]                      cuenta_q;
  logic                            aceptar;

  assign aceptar = (estado_q == REPOSO) && solicitud;

  // Outputs decode the registered state only, so no input reaches them combinationally.
  assign listo                  = (estado_q == REPOSO);
  assign habilitacion_registros = (estado_q == ESCRIBE_DIR) || (estado_q == ESCRIBE_LECT) ||
                                  (estado_q == ESCRIBE_BUF);
  assign configuracion_completa = (estado_q == FIN);
  assign error_configuracion    = (estado_q == ERROR);

  always_comb begin
    // NOTE: default first so every path assigns estado_sig and no latch is inferred.
    estado_sig = estado_q;
    unique case (estado_q)
      REPOSO: begin
        if (solicitud) begin
          estado_sig = (cantidad_lecturas == '0 || cantidad_buffers == '0) ? ERROR : ESCRIBE_DIR;
        end
      end
      ESCRIBE_DIR:  estado_sig = HAY_ESPERA ? ESPERA : ESCRIBE_LECT;
      ESCRIBE_LECT: estado_sig = HAY_ESPERA ? ESPERA : ESCRIBE_BUF;
      ESCRIBE_BUF:  estado_sig = HAY_ESPERA ? ESPERA : FIN;
      ESPERA: begin
        // The address register still names the write just issued, which picks the successor.
        if (cuenta_q == 4'd0) begin
          if (direccion_registros == REG_DIR)       estado_sig = ESCRIBE_LECT;
          else if (direccion_registros == REG_LECT) estado_sig = ESCRIBE_BUF;
          else                                      estado_sig = FIN;
        end
      end
      FIN:     estado_sig = REPOSO;
      ERROR:   estado_sig = REPOSO;
      default: estado_sig = REPOSO;
    endcase
  end

  // NOTE: every register, including the captured fields and bus outputs, is cleared
  // by reset so a sequence aborted mid-way leaves no stale state behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q            <= REPOSO;
      lecturas_q          <= '0;
      buffers_q           <= '0;
      cuenta_q            <= '0;
      direccion_registros <= '0;
      datos_registros     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      estado_q <= estado_sig;

      if (aceptar) begin
        lecturas_q <= cantidad_lecturas;
        buffers_q  <= cantidad_buffers;
      end

      if (estado_sig == ESPERA && estado_q != ESPERA) begin
        cuenta_q <= CARGA_ESPERA;
      end else if (estado_q == ESPERA) begin
        cuenta_q <= cuenta_q - 4'd1;
      end

      // ESCRIBE_DIR is entered only from REPOSO, so the start address is taken at acceptance.
      case (estado_sig)
        ESCRIBE_DIR: begin
          direccion_registros <= REG_DIR;
          datos_registros     <= BITS_BUS_DATOS_INSTR'(direccion_inicio);
        end
        ESCRIBE_LECT: begin
          direccion_registros <= REG_LECT;
          datos_registros     <= BITS_BUS_DATOS_INSTR'(lecturas_q);
        end
        ESCRIBE_BUF: begin
          direccion_registros <= REG_BUF;
          datos_registros     <= BITS_BUS_DATOS_INSTR'(buffers_q);
        end
        default: begin
          direccion_registros <= direccion_registros;
          datos_registros     <= datos_registros;
        end
      endcase
    end
  end

endmodule
